// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: loader FSM state enum, reply bytes, word geometry.
package loader_pkg;

    // Instruction words are always four bytes, sent MSB first.
    localparam int BYTES_PER_WORD = 4;
    localparam int IWIDTH         = BYTES_PER_WORD * 8;

    // Reply bytes returned to the host over the UART transmitter.
    localparam logic [7:0] ACK_BYTE = 8'hAA;
    localparam logic [7:0] NAK_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CK,
        S_ACK,
        S_NAK,
        S_RUN,
        S_ERR
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Byte-to-word shift register: collects four bytes MSB first into one word.
// Latency: combinational; o_word/o_word_done are valid in the cycle of the 4th byte.
// Backpressure: none; every strobed byte is taken.
//
// Ports:
//   clk, rstn      clock and synchronous active-low reset (drops any partial word)
//   i_byte_vld     byte strobe
//   i_byte         byte value
//   o_word         assembled word including the current byte
//   o_word_done    high in the cycle the final byte of a word is strobed in
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_byte_vld,
    input  logic [7:0]        i_byte,
    output logic [IWIDTH-1:0] o_word,
    output logic              o_word_done
);

    // Only the first three bytes need storage; the fourth is taken straight
    // from the input so the consumer can act on the word in the same cycle.
    logic [IWIDTH-9:0] r_shift;
    logic [1:0]        r_idx;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_byte_vld) begin
            r_shift <= {r_shift[IWIDTH-17:0], i_byte};
            r_idx   <= r_idx + 2'd1;
        end
    end

    assign o_word      = {r_shift, i_byte};
    assign o_word_done = i_byte_vld && (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: frames UART bytes into instruction words, writes imem from 0, checks the byte sum, replies ACK/NAK, then releases the core.
// Latency: last data byte -> imem_we 1 cycle; checksum byte -> tx_valid 1 cycle; tx handshake -> cpu_rstn 1 cycle.
// Backpressure: rx has none (bytes during the reply are dropped); tx_valid holds with stable data until tx_ready.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   i_rx_data/i_rx_valid      received byte and its 1-cycle strobe
//   o_tx_data/o_tx_valid      reply byte, held until i_tx_ready
//   i_tx_ready                transmitter accepts o_tx_data
//   o_imem_addr/o_imem_wdata  instruction memory word address / data (held between writes)
//   o_imem_we                 1-cycle write strobe
//   o_cpu_rstn                core reset, released only once the load is acknowledged
//   o_load_err                sticky error flag
module program_loader
    import loader_pkg::*;
#(
    parameter int PHYS_AWIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic [PHYS_AWIDTH-1:0] o_imem_addr,
    output logic [IWIDTH-1:0]      o_imem_wdata,
    output logic                   o_imem_we,
    output logic                   o_cpu_rstn,
    output logic                   o_load_err
);

    // Capacity in words, one bit wider than LEN so LEN == DEPTH compares cleanly.
    localparam logic [32:0] DEPTH = 33'd1 << PHYS_AWIDTH;

    state_t                 r_state;
    logic [31:0]            r_len;
    logic [31:0]            r_wc;
    logic [7:0]             r_sum8;
    logic [7:0]             r_tx_data;
    logic                   r_tx_valid;
    logic [PHYS_AWIDTH-1:0] r_imem_addr;
    logic [IWIDTH-1:0]      r_imem_wdata;
    logic                   r_imem_we;
    logic                   r_cpu_rstn;
    logic                   r_load_err;

    logic                   w_feed;
    logic [IWIDTH-1:0]      w_word;
    logic                   w_word_done;

    // The same assembler frames the length field and the data words; its
    // byte index wraps to 0 after LEN, so data framing starts aligned.
    assign w_feed = i_rx_valid && ((r_state == S_LEN) || (r_state == S_DATA));

    word_assembler u_asm (
        .clk         (clk),
        .rstn        (rstn),
        .i_byte_vld  (w_feed),
        .i_byte      (i_rx_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_LEN;
            r_len        <= '0;
            r_wc         <= '0;
            r_sum8       <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_imem_we    <= 1'b0;
            r_cpu_rstn   <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_word_done) begin
                        if ({1'b0, w_word} > DEPTH) begin
                            r_state    <= S_NAK;
                            r_tx_data  <= NAK_BYTE;
                            r_tx_valid <= 1'b1;
                        end else if (w_word == '0) begin
                            r_state <= S_CK;
                        end else begin
                            r_state <= S_DATA;
                            r_len   <= w_word;
                            r_wc    <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (i_rx_valid) begin
                        r_sum8 <= r_sum8 + i_rx_data;
                        // Write port is its own register stage, so the
                        // assembler keeps taking bytes while the strobe is out.
                        if (w_word_done) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_wc[PHYS_AWIDTH-1:0];
                            r_imem_wdata <= w_word;
                            r_wc         <= r_wc + 32'd1;
                            if (r_wc == r_len - 32'd1) begin
                                r_state <= S_CK;
                            end
                        end
                    end
                end
                S_CK: begin
                    if (i_rx_valid) begin
                        r_tx_valid <= 1'b1;
                        if (i_rx_data == r_sum8) begin
                            r_state   <= S_ACK;
                            r_tx_data <= ACK_BYTE;
                        end else begin
                            r_state   <= S_NAK;
                            r_tx_data <= NAK_BYTE;
                        end
                    end
                end
                S_ACK: begin
                    if (r_tx_valid && i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_cpu_rstn <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_NAK: begin
                    if (r_tx_valid && i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_load_err <= 1'b1;
                        r_state    <= S_ERR;
                    end
                end
                S_RUN, S_ERR: begin
                    // Terminal until rstn; incoming bytes are ignored.
                end
                default: begin
                    r_state <= S_ERR;
                end
            endcase
        end
    end

    assign o_tx_data    = r_tx_data;
    assign o_tx_valid   = r_tx_valid;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_imem_we    = r_imem_we;
    assign o_cpu_rstn   = r_cpu_rstn;
    assign o_load_err   = r_load_err;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int         PA  = 4;
    localparam logic [7:0] ACK = 8'hAA;
    localparam logic [7:0] NAK = 8'hEE;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          rx_valid = 1'b0;
    logic          tx_ready = 1'b1;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic [PA-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_we;
    logic          cpu_rstn;
    logic          load_err;

    program_loader #(.PHYS_AWIDTH(PA)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_imem_we    (imem_we),
        .o_cpu_rstn   (cpu_rstn),
        .o_load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PA-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    int          wr_count = 0;
    int          wb;
    int          cyc;
    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] words[16];
    logic [7:0]  exp_sum;
    wr_t         mon_wr;
    logic [7:0]  mon_tx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes memory or completes a tx handshake.
    always @(negedge clk) begin
        if (rstn) begin
            if (imem_we) begin
                wr_count++;
                check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) begin
                    mon_wr = exp_wr.pop_front();
                    check("wr_addr", 64'(imem_addr), 64'(mon_wr.addr));
                    check("wr_data", 64'(imem_wdata), 64'(mon_wr.data));
                end
            end
            if (tx_valid && tx_ready) begin
                check("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
                if (exp_tx.size() != 0) begin
                    mon_tx = exp_tx.pop_front();
                    check("tx_data", 64'(tx_data), 64'(mon_tx));
                end
            end
        end
    end

    // Each call occupies exactly one cycle, so consecutive calls give back-to-back bytes.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({tx_data, tx_valid, imem_addr, imem_wdata, imem_we, cpu_rstn, load_err}), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic end_test(input string name);
        check({name, "_writes_drained"}, 64'(exp_wr.size()), 64'd0);
        check({name, "_tx_drained"}, 64'(exp_tx.size()), 64'd0);
    endtask

    // LEN then n words from words[]; queues the expected writes and the byte sum.
    task automatic send_payload(input logic [31:0] len, input int n);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) send_byte(len[31-8*i -: 8]);
        exp_sum = 8'h00;
        for (int w = 0; w < n; w++) begin
            exp_wr.push_back({PA'(w), words[w]});
            for (int k = 0; k < 4; k++) begin
                b = words[w][31-8*k -: 8];
                exp_sum = exp_sum + b;
                send_byte(b);
            end
        end
    endtask

    task automatic send_ck(input logic [7:0] ck);
        exp_tx.push_back((ck == exp_sum) ? ACK : NAK);
        send_byte(ck);
    endtask

    // Returns at the negedge of the handshake cycle; cycles = negedges waited (0 on timeout).
    task automatic wait_handshake(input string name, output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                cycles = i + 1;
                break;
            end
        end
        check({name, "_handshake_seen"}, 64'(cycles != 0), 64'd1);
    endtask

    initial begin
        words[0] = 32'h20010005;
        words[1] = 32'h2002FFFF;
        do_reset();

        // 1) Two-word load with correct checksum (byte sum 0x46).
        wb = wr_count;
        send_payload(32'd2, 2);
        @(negedge clk);
        check("t1_we_latency", 64'(imem_we), 64'd1);
        @(posedge clk);
        #1;
        send_ck(exp_sum);
        wait_handshake("t1", cyc);
        check("t1_ck_to_tx_latency", 64'(cyc), 64'd1);
        check("t1_cpu_rstn_at_hs", 64'(cpu_rstn), 64'd0);
        @(negedge clk);
        check("t1_cpu_rstn_after", 64'(cpu_rstn), 64'd1);
        check("t1_load_err", 64'(load_err), 64'd0);
        check("t1_write_count", 64'(wr_count - wb), 64'd2);
        @(posedge clk);
        #1;
        end_test("t1");
        do_reset();

        // 2) Same frame, bad checksum; later bytes must not write.
        send_payload(32'd2, 2);
        send_ck(8'h00);
        wait_handshake("t2", cyc);
        @(negedge clk);
        check("t2_load_err", 64'(load_err), 64'd1);
        check("t2_cpu_rstn", 64'(cpu_rstn), 64'd0);
        @(posedge clk);
        #1;
        wb = wr_count;
        for (int i = 0; i < 10; i++) send_byte(8'(i * 7 + 1));
        idle(2);
        check("t2_no_writes_in_err", 64'(wr_count - wb), 64'd0);
        check("t2_err_sticky", 64'({load_err, cpu_rstn, tx_valid}), 64'b100);
        end_test("t2");
        do_reset();

        // 3a) LEN=0, CK=0 -> ACK without writes.
        wb = wr_count;
        send_payload(32'd0, 0);
        send_ck(8'h00);
        wait_handshake("t3a", cyc);
        @(negedge clk);
        check("t3a_cpu_rstn", 64'(cpu_rstn), 64'd1);
        check("t3a_no_writes", 64'(wr_count - wb), 64'd0);
        @(posedge clk);
        #1;
        end_test("t3a");
        do_reset();

        // 3b) LEN=17 exceeds 16-word memory -> immediate NAK.
        wb = wr_count;
        exp_tx.push_back(NAK);
        send_payload(32'd17, 0);
        wait_handshake("t3b", cyc);
        check("t3b_nak_latency", 64'(cyc), 64'd1);
        @(negedge clk);
        check("t3b_load_err", 64'({load_err, cpu_rstn}), 64'b10);
        check("t3b_no_writes", 64'(wr_count - wb), 64'd0);
        @(posedge clk);
        #1;
        end_test("t3b");
        do_reset();

        // 4) Transmitter stalls for 20 cycles in ACK.
        tx_ready = 1'b0;
        send_payload(32'd0, 0);
        send_ck(8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t4_stall_hold", 64'({tx_valid, tx_data, cpu_rstn}), 64'({1'b1, ACK, 1'b0}));
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_handshake("t4", cyc);
        check("t4_cpu_rstn_at_hs", 64'(cpu_rstn), 64'd0);
        @(negedge clk);
        check("t4_cpu_rstn_after", 64'(cpu_rstn), 64'd1);
        @(posedge clk);
        #1;
        end_test("t4");
        do_reset();

        // 5) Reset mid-word, then a clean reload from address 0.
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        exp_wr.push_back({PA'(0), words[0]});
        for (int k = 0; k < 4; k++) send_byte(words[0][31-8*k -: 8]);
        send_byte(8'h20);
        send_byte(8'h02);
        end_test("t5_partial");
        do_reset();
        wb = wr_count;
        send_payload(32'd2, 2);
        send_ck(exp_sum);
        wait_handshake("t5", cyc);
        @(negedge clk);
        check("t5_cpu_rstn", 64'(cpu_rstn), 64'd1);
        check("t5_write_count", 64'(wr_count - wb), 64'd2);
        @(posedge clk);
        #1;
        end_test("t5");
        do_reset();

        // 6) Full 16-word memory, bytes back-to-back every cycle.
        for (int i = 0; i < 16; i++) words[i] = {8'(i), 8'hC3, 8'(i * 17), 8'(~i)};
        wb = wr_count;
        send_payload(32'd16, 16);
        send_ck(exp_sum);
        wait_handshake("t6", cyc);
        @(negedge clk);
        check("t6_cpu_rstn", 64'(cpu_rstn), 64'd1);
        check("t6_write_count", 64'(wr_count - wb), 64'd16);
        @(posedge clk);
        #1;
        end_test("t6");
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
